// File: rtl/alu_pkg.sv
// Shared ALU definitions: default adder geometry and the add/sub result bundle.
package alu_pkg;

    localparam int unsigned ADDSUB_N_DEFAULT      = 32;
    localparam int unsigned ADDSUB_STAGES_DEFAULT = 4;

    typedef struct packed {
        logic [ADDSUB_N_DEFAULT-1:0] c;
        logic                        cout;
        logic                        ovf;
    } addsub_result_t;

endpackage

// File: rtl/addsub_segment.sv
// Combinational W-bit slice of the pipelined adder: sum, carry out, and carry
// into the slice MSB (used for signed overflow in the top slice).
module addsub_segment
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] sum_w;

    assign sum_w = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s     = sum_w[W-1:0];
    assign cout  = sum_w[W];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out by XOR.
    assign cmsb  = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// Optional saturation on signed overflow: define PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int unsigned N      = ADDSUB_N_DEFAULT,
    parameter int unsigned STAGES = ADDSUB_STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned SEG = N / STAGES;

    logic              adv;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] cy_q;
    logic              ovf_q;
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic [N-1:0]      r_q   [STAGES];

    // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
    logic [N-1:0]      a_cur [STAGES];
    logic [N-1:0]      b_cur [STAGES];
    logic [N-1:0]      r_cur [STAGES];
    logic [N-1:0]      r_nxt [STAGES];
    logic [STAGES-1:0] cy_cur;
    logic [STAGES-1:0] cy_out;
    logic              cm_out [STAGES];
    logic [SEG-1:0]    sum_s  [STAGES];
    logic              ovf_nxt;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign c         = r_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = ovf_q;

    always_comb begin
        a_cur[0]  = a;
        b_cur[0]  = sub ? ~b : b;
        r_cur[0]  = '0;
        cy_cur[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            a_cur[k]  = a_q[k-1];
            b_cur[k]  = b_q[k-1];
            r_cur[k]  = r_q[k-1];
            cy_cur[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        addsub_segment #(
            .W (SEG)
        ) u_seg (
            .a    (a_cur[k][k*SEG +: SEG]),
            .b    (b_cur[k][k*SEG +: SEG]),
            .cin  (cy_cur[k]),
            .s    (sum_s[k]),
            .cout (cy_out[k]),
            .cmsb (cm_out[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_nxt[k]                = r_cur[k];
            r_nxt[k][k*SEG +: SEG]  = sum_s[k];
        end
        // Signed overflow: carry into the MSB disagrees with carry out of it.
        ovf_nxt = cm_out[STAGES-1] ^ cy_out[STAGES-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (ovf_nxt) begin
            r_nxt[STAGES-1] = a_cur[STAGES-1][N-1] ? {1'b1, {(N-1){1'b0}}}
                                                   : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cy_q    <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            cy_q  <= cy_out;
            ovf_q <= ovf_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_cur[k];
                b_q[k] <= b_cur[k];
                r_q[k] <= r_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed, random, backpressure and reset
// on a 32-bit/4-stage instance, plus an 8-bit sweep over STAGES = 1, 2, 8.
module tb_pipelined_addsub;

    localparam int unsigned N      = 32;
    localparam int unsigned STAGES = 4;

    typedef struct {
        logic [31:0] c;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Main 32-bit instance
    logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [N-1:0] a, b, c;
    exp_t         exp_q[$];

    pipelined_addsub #(
        .N      (N),
        .STAGES (STAGES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .cout      (cout),
        .ovf       (ovf)
    );

    // 8-bit sweep instances sharing one stimulus
    logic       sw_rst_n, sw_valid, sw_sub;
    logic [7:0] sw_a, sw_b;
    logic       sw_ir1, sw_ir2, sw_ir8, sw_ov1, sw_ov2, sw_ov8;
    logic       sw_co1, sw_co2, sw_co8, sw_of1, sw_of2, sw_of8;
    logic [7:0] sw_c1, sw_c2, sw_c8;
    exp_t       sw_q1[$], sw_q2[$], sw_q8[$];

    pipelined_addsub #(.N(8), .STAGES(1)) u_sw1 (
        .clk (clk), .rst_n (sw_rst_n), .in_valid (sw_valid), .in_ready (sw_ir1),
        .a (sw_a), .b (sw_b), .sub (sw_sub), .out_valid (sw_ov1), .out_ready (1'b1),
        .c (sw_c1), .cout (sw_co1), .ovf (sw_of1)
    );
    pipelined_addsub #(.N(8), .STAGES(2)) u_sw2 (
        .clk (clk), .rst_n (sw_rst_n), .in_valid (sw_valid), .in_ready (sw_ir2),
        .a (sw_a), .b (sw_b), .sub (sw_sub), .out_valid (sw_ov2), .out_ready (1'b1),
        .c (sw_c2), .cout (sw_co2), .ovf (sw_of2)
    );
    pipelined_addsub #(.N(8), .STAGES(8)) u_sw8 (
        .clk (clk), .rst_n (sw_rst_n), .in_valid (sw_valid), .in_ready (sw_ir8),
        .a (sw_a), .b (sw_b), .sub (sw_sub), .out_valid (sw_ov8), .out_ready (1'b1),
        .c (sw_c8), .cout (sw_co8), .ovf (sw_of8)
    );

    // Reference: unsigned arithmetic for c/cout, signed integer range test for ovf.
    function automatic exp_t model(int unsigned n, longint unsigned ua, longint unsigned ub,
                                   logic s);
        exp_t            e;
        longint unsigned mask, full;
        longint          half, sa, sb, sr;
        mask = (64'd1 << n) - 64'd1;
        half = longint'(64'd1 << (n - 1));
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (sa >= half) sa = sa - 2 * half;
        if (sb >= half) sb = sb - 2 * half;
        if (s) begin
            e.cout = (ua >= ub);
            full   = ua - ub;
            sr     = sa - sb;
        end else begin
            full   = ua + ub;
            e.cout = ((full >> n) & 64'd1) != 64'd0;
            sr     = sa + sb;
        end
        e.c   = 32'(full & mask);
        e.ovf = (sr >= half) || (sr < -half);
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (e.ovf) e.c = (sa < 0) ? 32'(half) : 32'(half - 1);
`endif
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic cmp(string name, exp_t e, logic [31:0] gc, logic gco, logic gov);
        n_cmp++;
        if (gc !== e.c || gco !== e.cout || gov !== e.ovf) begin
            n_bad++;
            $display("FAIL %s: got c=%h cout=%b ovf=%b, want c=%h cout=%b ovf=%b",
                     name, gc, gco, gov, e.c, e.cout, e.ovf);
        end
    endtask

    // Main monitor state
    logic        stall_prev = 1'b0;
    logic [31:0] held_c;
    logic        held_cout, held_ovf;

    task automatic main_step();
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            chk("stall_hold_c", c, held_c);
            chk("stall_hold_flags", {30'd0, cout, ovf}, {30'd0, held_cout, held_ovf});
        end
        if (out_valid && !out_ready) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got c=%h with nothing outstanding, want none", c);
            end else begin
                e = exp_q.pop_front();
                cmp("result", e, c, cout, ovf);
            end
        end
        stall_prev = out_valid && !out_ready;
        held_c     = c;
        held_cout  = cout;
        held_ovf   = ovf;
    endtask

    always @(negedge clk) main_step();

    task automatic sw_step(string name, ref exp_t q[$], input logic ov, input logic [7:0] cc,
                           input logic co, input logic of);
        exp_t e;
        if (!sw_rst_n || !ov) return;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_unexpected: got c=%h with nothing outstanding, want none", name, cc);
            return;
        end
        e = q.pop_front();
        cmp(name, e, {24'd0, cc}, co, of);
    endtask

    always @(negedge clk) sw_step("sweep_s1", sw_q1, sw_ov1, sw_c1, sw_co1, sw_of1);
    always @(negedge clk) sw_step("sweep_s2", sw_q2, sw_ov2, sw_c2, sw_co2, sw_of2);
    always @(negedge clk) sw_step("sweep_s8", sw_q8, sw_ov8, sw_c8, sw_co8, sw_of8);

    // All main-bench tasks start and end at posedge + 1.
    task automatic send(logic [31:0] ta, logic [31:0] tb_v, logic ts, exp_t e);
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, want 1");
    endtask

    task automatic send_rand();
        logic [31:0] ra, rb;
        logic        rs;
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom);
        send(ra, rb, rs, model(32, 64'(ra), 64'(rb), rs));
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_latency(string name);
        int n = 0;
        for (int t = 1; t <= 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                n = t;
                break;
            end
        end
        chk(name, 32'(n), 32'(STAGES));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic directed(string name, logic [31:0] ta, logic [31:0] tb_v, logic ts,
                            logic [31:0] ec, logic eco, logic eov);
        exp_t e;
        e.c    = ec;
        e.cout = eco;
        e.ovf  = eov;
        send(ta, tb_v, ts, e);
        expect_latency(name);
    endtask

    logic sending;

    task automatic run_main();
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_c", c, 32'd0);
        chk("reset_flags", {30'd0, cout, ovf}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        idle(1);

        directed("lat_add", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        directed("lat_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("lat_sub_neg", 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
        directed("lat_sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        directed("lat_add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
        directed("lat_sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("lat_add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif
        directed("lat_sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Back-to-back stream at full throughput
        for (int i = 0; i < 50; i++) send_rand();
        drain("drain_stream");

        // Backpressure window in the middle of an 8-op stream
        fork
            for (int i = 0; i < 8; i++) send_rand();
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Random gaps and random backpressure
        sending = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                sending = 1'b0;
            end
            while (sending) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        // Asynchronous reset with operations in flight
        for (int i = 0; i < 6; i++) send_rand();
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_c", c, 32'd0);
        chk("midreset_flags", {30'd0, cout, ovf}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("post_reset_no_stale", 32'(seen), 32'd0);
        directed("post_reset_latency", 32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 32'hDEAD_D000,
                 1'b0, 1'b0);
        drain("drain_final");
    endtask

    task automatic run_sweep();
        exp_t e;
        sw_rst_n = 1'b0;
        sw_valid = 1'b0;
        sw_a     = '0;
        sw_b     = '0;
        sw_sub   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sw_rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            sw_a     = 8'(i);
            sw_b     = 8'(i >> 8);
            sw_sub   = 1'($urandom);
            sw_valid = 1'b1;
            @(negedge clk);
            if (i % 4096 == 0) chk("sweep_in_ready", {29'd0, sw_ir1, sw_ir2, sw_ir8}, 32'd7);
            e = model(8, 64'(sw_a), 64'(sw_b), sw_sub);
            sw_q1.push_back(e);
            sw_q2.push_back(e);
            sw_q8.push_back(e);
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("sweep_drained", 32'(sw_q1.size() + sw_q2.size() + sw_q8.size()), 32'd0);
    endtask

    initial begin
        fork
            run_main();
            run_sweep();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1);
    end

endmodule
